// File: rtl/exec_sequencer_if.sv
// Handshake and strobe bundle between exec_sequencer and its surroundings
// (instruction/data memory, instruction decoder, register file, CSRs, PC).
// master: the sequencer.  slave: the environment it controls.
interface exec_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic        pc_en;
  logic        invalid;
  logic [18:0] alu_op;
  logic [8:0]  mem_op;
  logic [8:0]  jmp_op;
  logic [5:0]  csr_op;
  logic [7:0]  machine_op;
  logic        cust_op;
  logic        br_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        cust_start;
  logic        cust_done;
  logic        rf_we;
  logic        csr_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        trap;
  logic [3:0]  trap_cause;
  logic        halted;
  logic        resume;
  logic [2:0]  state;

  modport master (
    output imem_req, ir_we, pc_en, dmem_req, dmem_we, cust_start,
           rf_we, csr_we, pc_we, pc_sel, trap, trap_cause, halted, state,
    input  imem_ack, invalid, alu_op, mem_op, jmp_op, csr_op, machine_op,
           cust_op, br_taken, dmem_ack, cust_done, resume
  );

  modport slave (
    input  imem_req, ir_we, pc_en, dmem_req, dmem_we, cust_start,
           rf_we, csr_we, pc_we, pc_sel, trap, trap_cause, halted, state,
    output imem_ack, invalid, alu_op, mem_op, jmp_op, csr_op, machine_op,
           cust_op, br_taken, dmem_ack, cust_done, resume
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM that walks one instruction at a
// time through fetch, decode, execute, memory and write-back, and sequences
// traps (illegal, ecall, bus timeout) and ebreak halts.
// Optional custom-unit path: define CUST_OP_EN to enable the CUST state.
//
// state  | meaning
// FETCH  | imem_req held until imem_ack or fetch timeout
// DECODE | decoder enabled, instruction class captured
// EXEC   | class dispatched, branch outcome latched
// MEM    | dmem_req held until dmem_ack or data timeout
// WB     | retire: pc_we plus register-file / CSR write strobes
// TRAP   | trap pulse with cause, PC loads trap vector
// HALT   | parked after ebreak until resume
// CUST   | custom unit busy (CUST_OP_EN builds only)
module exec_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  exec_sequencer_if.master bus
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [3:0] CAUSE_IFAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_LFAULT  = 4'd5;
  localparam logic [3:0] CAUSE_SFAULT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_TGT  = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6,
    S_CUST   = 3'd7
  } state_t;

  // Instruction class as captured at the end of DECODE.
  typedef enum logic [3:0] {
    C_NONE, C_ILL, C_ECALL, C_EBREAK, C_CUST, C_LUI,
    C_LOAD, C_STORE, C_JUMP, C_BRANCH, C_CSR, C_ALU
  } class_t;

  state_t        state_q, state_d;
  class_t        cls_q, cls_d, cls_dec;
  logic [3:0]    cause_q, cause_d;
  logic          taken_q, taken_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Low only between reset release and the first clock, so imem_req
  // cannot be asserted while the block is still held in reset.
  logic          run_q;

  logic          imem_req, ir_we, pc_en, dmem_req, dmem_we, cust_start;
  logic          rf_we, csr_we, pc_we, trap, halted;
  logic [1:0]    pc_sel;
  logic [3:0]    trap_cause;

`ifdef CUST_OP_EN
  logic          cust_entry_q, cust_entry_d;
`else
  logic          unused_cust_done;
  assign unused_cust_done = bus.cust_done;
`endif

  // Classify the decoder's one-hot buses by fixed priority.
  // jmp_op[1:0] are the unconditional jumps (jal, jalr); the remaining
  // jmp_op bits are conditional branches resolved through br_taken.
  always_comb begin
    cls_dec = C_NONE;
    if (bus.invalid) begin
      cls_dec = C_ILL;
    end else if (|bus.machine_op) begin
      if (bus.machine_op[1])      cls_dec = C_ECALL;
      else if (bus.machine_op[0]) cls_dec = C_EBREAK;
      else                        cls_dec = C_NONE;
    end else if (bus.cust_op) begin
`ifdef CUST_OP_EN
      cls_dec = C_CUST;
`else
      cls_dec = C_ILL;
`endif
    end else if (|bus.mem_op) begin
      if (bus.mem_op[0])           cls_dec = C_LUI;
      else if (|bus.mem_op[8:6])   cls_dec = C_STORE;
      else                         cls_dec = C_LOAD;
    end else if (|bus.jmp_op) begin
      if (|bus.jmp_op[1:0]) cls_dec = C_JUMP;
      else                  cls_dec = C_BRANCH;
    end else if (|bus.csr_op) begin
      cls_dec = C_CSR;
    end else if (|bus.alu_op) begin
      cls_dec = C_ALU;
    end
  end

  // Next-state logic, wait counter and trap-cause capture.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
`ifdef CUST_OP_EN
    cust_entry_d = 1'b0;
`endif
    unique case (state_q)
      S_FETCH: begin
        if (run_q) begin
          if (bus.imem_ack) begin
            state_d = S_DECODE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_IFAULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (cls_q)
          C_ILL: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
          C_ECALL: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ECALL;
          end
          C_EBREAK: state_d = S_HALT;
          C_CUST: begin
`ifdef CUST_OP_EN
            state_d      = S_CUST;
            cust_entry_d = 1'b1;
`else
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
`endif
          end
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          C_BRANCH: begin
            taken_d = bus.br_taken;
            state_d = S_WB;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = (cls_q == C_STORE) ? CAUSE_SFAULT : CAUSE_LFAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB, S_TRAP: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_HALT: begin
        if (bus.resume) begin
          state_d = S_WB;
          cls_d   = C_NONE;
        end
      end
      S_CUST: begin
`ifdef CUST_OP_EN
        if (bus.cust_done) state_d = S_WB;
`else
        state_d = S_FETCH;
        cnt_d   = '0;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FSM state and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      cause_q <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

`ifdef CUST_OP_EN
  // Marks the first CUST cycle so cust_start is a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cust_entry_q <= 1'b0;
    else        cust_entry_q <= cust_entry_d;
  end
`endif

  // Output decode from registered state; only ir_we qualifies on imem_ack.
  always_comb begin
    imem_req   = (state_q == S_FETCH) && run_q;
    ir_we      = imem_req && bus.imem_ack;
    pc_en      = (state_q == S_DECODE);
    dmem_req   = (state_q == S_MEM);
    dmem_we    = dmem_req && (cls_q == C_STORE);
`ifdef CUST_OP_EN
    cust_start = (state_q == S_CUST) && cust_entry_q;
`else
    cust_start = 1'b0;
`endif
    rf_we      = (state_q == S_WB) &&
                 (cls_q inside {C_ALU, C_LUI, C_LOAD, C_JUMP, C_CSR, C_CUST});
    csr_we     = (state_q == S_WB) && (cls_q == C_CSR);
    pc_we      = (state_q == S_WB) || (state_q == S_TRAP);
    trap       = (state_q == S_TRAP);
    trap_cause = trap ? cause_q : 4'd0;
    halted     = (state_q == S_HALT);
    pc_sel     = SEL_SEQ;
    if (state_q == S_TRAP) begin
      pc_sel = SEL_TRAP;
    end else if ((state_q == S_WB) &&
                 ((cls_q == C_JUMP) || ((cls_q == C_BRANCH) && taken_q))) begin
      pc_sel = SEL_TGT;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_we      = ir_we;
  assign bus.pc_en      = pc_en;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.cust_start = cust_start;
  assign bus.rf_we      = rf_we;
  assign bus.csr_we     = csr_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.trap       = trap;
  assign bus.trap_cause = trap_cause;
  assign bus.halted     = halted;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer: directed cases followed by randomized
// instructions, each compared against a per-instruction reference model
// (cycle count and strobe tallies derived from the sequencing rules).
module tb_exec_sequencer;
  localparam int TIMEOUT = 16;

  localparam int K_NOP = 0, K_ILL = 1, K_ECALL = 2, K_EBREAK = 3, K_CUST = 4,
                 K_LUI = 5, K_LOAD = 6, K_STORE = 7, K_JUMP = 8, K_BRANCH = 9,
                 K_CSR = 10, K_ALU = 11;

  typedef struct {
    logic        invalid;
    logic [18:0] alu;
    logic [8:0]  mem;
    logic [8:0]  jmp;
    logic [5:0]  csr;
    logic [7:0]  mach;
    logic        cust;
    logic        br;
    int          fwait;
    int          mwait;
    int          hold;
    int          cwait;
    bit          rst_mid;
  } plan_t;

  typedef struct {
    int cyc, imreq, ir, pcen, dmreq, dmwe, rf, csr, pcwe, sel;
    int trap, cause, halt, cstart, wbstate;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exec_sequencer_if bus ();

  exec_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int out_word();
    return int'({bus.imem_req, bus.ir_we, bus.pc_en, bus.dmem_req, bus.dmem_we,
                 bus.cust_start, bus.rf_we, bus.csr_we, bus.pc_we, bus.pc_sel,
                 bus.trap, bus.trap_cause, bus.halted, bus.state});
  endfunction

  function automatic plan_t blank();
    plan_t p;
    p.invalid = 1'b0; p.alu = '0; p.mem = '0; p.jmp = '0; p.csr = '0;
    p.mach = '0; p.cust = 1'b0; p.br = 1'b0;
    p.fwait = 0; p.mwait = 0; p.hold = 0; p.cwait = 0; p.rst_mid = 1'b0;
    return p;
  endfunction

  // Instruction class by decoder priority.
  function automatic int kind_of(plan_t p);
    if (p.invalid) return K_ILL;
    if (p.mach != 0) return p.mach[1] ? K_ECALL : (p.mach[0] ? K_EBREAK : K_NOP);
    if (p.cust) begin
`ifdef CUST_OP_EN
      return K_CUST;
`else
      return K_ILL;
`endif
    end
    if (p.mem != 0) return p.mem[0] ? K_LUI : ((p.mem[8:6] != 0) ? K_STORE : K_LOAD);
    if (p.jmp != 0) return (p.jmp[1:0] != 0) ? K_JUMP : K_BRANCH;
    if (p.csr != 0) return K_CSR;
    if (p.alu != 0) return K_ALU;
    return K_NOP;
  endfunction

  // Expected totals for one instruction: fetch takes fwait+1 cycles, then
  // decode and exec one each, then the class-specific tail.
  function automatic obs_t model(plan_t p);
    obs_t e;
    int   k;
    int   base;
    e = '{default: 0};
    k = kind_of(p);
    if (p.fwait >= TIMEOUT) begin
      e.cyc = TIMEOUT + 1; e.imreq = TIMEOUT;
      e.trap = 1; e.cause = 1; e.pcwe = 1; e.sel = 2; e.wbstate = 5;
      return e;
    end
    e.imreq = p.fwait + 1; e.ir = 1; e.pcen = 1;
    base = p.fwait + 3;
    e.cyc = base + 1; e.pcwe = 1; e.wbstate = 4;
    case (k)
      K_ILL:    begin e.trap = 1; e.cause = 2;  e.sel = 2; e.wbstate = 5; end
      K_ECALL:  begin e.trap = 1; e.cause = 11; e.sel = 2; e.wbstate = 5; end
      K_EBREAK: begin e.halt = p.hold + 1; e.cyc = base + p.hold + 2; end
      K_LOAD, K_STORE: begin
        e.dmwe = (k == K_STORE) ? 1 : 0;
        if (p.mwait >= TIMEOUT) begin
          e.dmreq = TIMEOUT; e.cyc = base + TIMEOUT + 1;
          e.trap = 1; e.cause = (k == K_STORE) ? 7 : 5; e.sel = 2; e.wbstate = 5;
        end else begin
          e.dmreq = p.mwait + 1; e.cyc = base + p.mwait + 2;
          e.rf = (k == K_LOAD) ? 1 : 0;
        end
      end
      K_JUMP:   begin e.rf = 1; e.sel = 1; end
      K_BRANCH: e.sel = p.br ? 1 : 0;
      K_CSR:    begin e.rf = 1; e.csr = 1; end
      K_ALU, K_LUI: e.rf = 1;
      K_CUST:   begin e.rf = 1; e.cstart = 1; e.cyc = base + p.cwait + 2; end
      default: ;
    endcase
    return e;
  endfunction

  // Plays memory, decoder and debugger for one instruction, starting at a
  // falling edge in FETCH; returns at the falling edge of the next FETCH.
  task automatic run(input string name, input plan_t p, output obs_t o, output bit aborted);
    int fc = 0, mc = 0, hc = 0, cc = 0, cyc = 0;
    bit left = 1'b0;
    o = '{default: 0};
    aborted = 1'b0;
    forever begin
      if (left && bus.state == 3'd0) break;
      if (bus.state != 3'd0) left = 1'b1;
      if (cyc > 300) begin
        check($sformatf("%s.watchdog", name), cyc, 300);
        break;
      end
      if (p.rst_mid && bus.dmem_req && mc == 3) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s.rst_outputs", name), out_word(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check($sformatf("%s.req_after_rst", name), int'(bus.imem_req), 0);
        @(negedge clk);
        aborted = 1'b1;
        return;
      end
      cyc++;
      if (bus.pc_en) begin
        bus.invalid = p.invalid; bus.alu_op = p.alu; bus.mem_op = p.mem;
        bus.jmp_op = p.jmp; bus.csr_op = p.csr; bus.machine_op = p.mach;
        bus.cust_op = p.cust;
      end else begin
        bus.invalid = 1'($urandom); bus.alu_op = 19'($urandom);
        bus.mem_op = 9'($urandom); bus.jmp_op = 9'($urandom);
        bus.csr_op = 6'($urandom); bus.machine_op = 8'($urandom);
        bus.cust_op = 1'($urandom);
      end
      bus.br_taken  = p.br;
      bus.imem_ack  = bus.imem_req ? (fc == p.fwait) : 1'($urandom);
      bus.dmem_ack  = bus.dmem_req ? (mc == p.mwait) : 1'($urandom);
      bus.resume    = bus.halted   ? (hc == p.hold)  : 1'($urandom);
      bus.cust_done = (bus.state == 3'd7) ? (cc == p.cwait) : 1'($urandom);
      if (bus.imem_req) fc++;
      if (bus.dmem_req) mc++;
      if (bus.halted) hc++;
      if (bus.state == 3'd7) cc++;
      #1;
      if (bus.imem_req) o.imreq++;
      if (bus.ir_we) o.ir++;
      if (bus.pc_en) o.pcen++;
      if (bus.dmem_req) o.dmreq++;
      if (bus.dmem_req && bus.dmem_we) o.dmwe = 1;
      if (bus.rf_we) o.rf++;
      if (bus.csr_we) o.csr++;
      if (bus.pc_we) begin
        o.pcwe++;
        o.sel = int'(bus.pc_sel);
        o.wbstate = int'(bus.state);
      end
      if (bus.trap) begin
        o.trap++;
        o.cause = int'(bus.trap_cause);
      end
      if (bus.halted) o.halt++;
      if (bus.cust_start) o.cstart++;
      o.cyc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic go(input string name, input plan_t p);
    obs_t o, e;
    bit   ab;
    run(name, p, o, ab);
    if (!ab) begin
      e = model(p);
      check($sformatf("%s.cycles", name),    o.cyc,     e.cyc);
      check($sformatf("%s.imem_req", name),  o.imreq,   e.imreq);
      check($sformatf("%s.ir_we", name),     o.ir,      e.ir);
      check($sformatf("%s.pc_en", name),     o.pcen,    e.pcen);
      check($sformatf("%s.dmem_req", name),  o.dmreq,   e.dmreq);
      check($sformatf("%s.dmem_we", name),   o.dmwe,    e.dmwe);
      check($sformatf("%s.rf_we", name),     o.rf,      e.rf);
      check($sformatf("%s.csr_we", name),    o.csr,     e.csr);
      check($sformatf("%s.pc_we", name),     o.pcwe,    e.pcwe);
      check($sformatf("%s.pc_sel", name),    o.sel,     e.sel);
      check($sformatf("%s.trap", name),      o.trap,    e.trap);
      check($sformatf("%s.cause", name),     o.cause,   e.cause);
      check($sformatf("%s.halted", name),    o.halt,    e.halt);
      check($sformatf("%s.cust_start", name), o.cstart, e.cstart);
      check($sformatf("%s.retire_state", name), o.wbstate, e.wbstate);
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 3));
    return int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
  endfunction

  initial begin
    plan_t p;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.invalid = 1'b0;
    bus.alu_op = '0; bus.mem_op = '0; bus.jmp_op = '0; bus.csr_op = '0;
    bus.machine_op = '0; bus.cust_op = 1'b0; bus.br_taken = 1'b0;
    bus.cust_done = 1'b0; bus.resume = 1'b0;

    #1;
    check("rst_outputs", out_word(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_outputs", out_word(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_before_first_clk", int'(bus.imem_req), 0);
    @(negedge clk);
    check("req_after_first_clk", int'(bus.imem_req), 1);

    p = blank(); p.alu[0] = 1'b1;                 go("addi", p);
    p = blank(); p.mem[3] = 1'b1; p.mwait = 3;    go("lw_wait3", p);
    p = blank(); p.mem[7] = 1'b1;                 go("sw", p);
    p = blank(); p.jmp[2] = 1'b1; p.br = 1'b1;    go("beq_taken", p);
    p = blank(); p.jmp[2] = 1'b1; p.br = 1'b0;    go("beq_not_taken", p);
    p = blank(); p.jmp[0] = 1'b1;                 go("jal", p);
    p = blank(); p.invalid = 1'b1; p.alu[3] = 1'b1; go("illegal", p);
    p = blank(); p.mach[1] = 1'b1;                go("ecall", p);
    p = blank(); p.fwait = TIMEOUT;               go("fetch_timeout", p);
    p = blank(); p.fwait = TIMEOUT - 1; p.alu[1] = 1'b1; go("fetch_ack_last", p);
    p = blank(); p.mach[0] = 1'b1; p.hold = 10;   go("ebreak", p);
    p = blank(); p.mem[0] = 1'b1;                 go("lui", p);
    p = blank(); p.csr[2] = 1'b1;                 go("csrrw", p);
    p = blank();                                  go("fence", p);
    p = blank(); p.mem[2] = 1'b1; p.mwait = TIMEOUT; go("load_timeout", p);
    p = blank(); p.mem[8] = 1'b1; p.mwait = TIMEOUT + 4; go("store_timeout", p);
    p = blank(); p.mem[1] = 1'b1; p.mwait = TIMEOUT - 1; go("load_ack_last", p);
    p = blank(); p.cust = 1'b1; p.cwait = 2;      go("cust", p);
    p = blank(); p.invalid = 1'b1; p.mach[1] = 1'b1; go("prio_ill_ecall", p);
    p = blank(); p.mach[1] = 1'b1; p.mem[4] = 1'b1; go("prio_ecall_mem", p);
    p = blank(); p.mem[6] = 1'b1; p.jmp[0] = 1'b1; p.alu[5] = 1'b1; go("prio_mem_jmp", p);
    p = blank(); p.mem[2] = 1'b1; p.mwait = 10; p.rst_mid = 1'b1; go("rst_mid_mem", p);
    p = blank(); p.alu[7] = 1'b1;                 go("addi_after_rst", p);

    for (int i = 0; i < 150; i++) begin
      p = blank();
      if ($urandom_range(0, 7) == 0) p.invalid = 1'b1;
      if ($urandom_range(0, 3) == 0) p.alu[$urandom_range(0, 18)] = 1'b1;
      if ($urandom_range(0, 3) == 0) p.mem[$urandom_range(0, 8)] = 1'b1;
      if ($urandom_range(0, 3) == 0) p.jmp[$urandom_range(0, 8)] = 1'b1;
      if ($urandom_range(0, 3) == 0) p.csr[$urandom_range(0, 5)] = 1'b1;
      if ($urandom_range(0, 4) == 0) p.mach[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 5) == 0) p.cust = 1'b1;
      p.br    = 1'($urandom);
      p.fwait = pick_wait();
      p.mwait = pick_wait();
      p.hold  = int'($urandom_range(0, 10));
      p.cwait = int'($urandom_range(0, 5));
      go($sformatf("rnd%0d", i), p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and write-back around the instruction decoder. It handshakes with instruction and data memory, enables the decoder, classifies its one-hot op buses, and drives register-file, CSR and PC write strobes. Traps (illegal instruction, ecall, bus timeout) and ebreak halts are also sequenced here.

## Interface
- TIMEOUT, 16: max cycles waiting for imem/dmem ack before an access-fault trap (≥2).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request; held until ack or timeout.
- imem_ack  in  1  fetch complete; instruction valid this cycle.
- ir_we  out  1  latch instruction register (pulse on accepted imem_ack).
- pc_en  out  1  decoder enable; high only in DECODE.
- invalid  in  1  decoder illegal-instruction flag.
- alu_op  in  19, mem_op  in  9, jmp_op  in  9, csr_op  in  6, machine_op  in  8, cust_op  in  1  decoder one-hot op buses.
- br_taken  in  1  branch compare result, sampled in EXEC.
- dmem_req  out  1  data access request; held until ack or timeout.
- dmem_we  out  1  store qualifier, valid with dmem_req.
- dmem_ack  in  1  data access complete.
- cust_start  out  1  custom unit start pulse (CUST_OP_EN only).
- cust_done  in  1  custom unit done (CUST_OP_EN only).
- rf_we  out  1  register-file write, one cycle.
- csr_we  out  1  CSR write, one cycle.
- pc_we  out  1  PC update, one cycle.
- pc_sel  out  2  00 pc+4, 01 jump/branch target, 10 trap vector.
- trap  out  1  trap pulse; trap_cause  out  4  mcause code, valid with trap.
- halted  out  1  high in HALT; resume  in  1  leave HALT.
- state  out  3  current state (debug).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, HALT=6, CUST=7.
- FETCH: imem_req=1; on imem_ack: ir_we=1, imem_req drops next cycle → DECODE.
- DECODE: pc_en=1; classify with priority invalid > machine_op > cust_op > mem_op > jmp_op > csr_op > alu_op > none; class registered at end of cycle → EXEC.
- EXEC: invalid → TRAP cause 2; machine_op[1] (ecall) → TRAP cause 11; machine_op[0] (ebreak) → HALT; cust → CUST; mem_op[0] (lui) → WB; other mem → MEM; branch: latch br_taken → WB; all else → WB.
- MEM: dmem_req=1, dmem_we=1 for store (mem_op[8:6]); on dmem_ack → WB.
- WB: pc_we=1; rf_we=1 for alu, lui, load, jal/jalr, auipc, csr, cust; csr_we=1 for csr; pc_sel=01 for jal/jalr and taken branch, else 00. No-class (e.g. fence) retires as NOP. → FETCH.
- TRAP: trap=1, trap_cause set, pc_we=1, pc_sel=10 → FETCH.
- HALT: halted=1; on resume → WB as NOP (pc+4).
- Timeout: counter clears on entering FETCH/MEM, increments each wait cycle; at TIMEOUT without ack, drop req → TRAP cause 1 (fetch), 5 (load), 7 (store). Ack in the cycle the count reaches TIMEOUT wins.

## Timing
- Reset: state=FETCH; every output 0 except state=0; imem_req rises in first clk after rst_n deasserts. Reset mid-transaction drops req asynchronously; no retry.
- Zero-wait latency: ALU/jump/CSR 4 cycles; load/store 5; trap 4; per extra ack-wait cycle +1.
- All strobes (ir_we, rf_we, csr_we, pc_we, trap, cust_start) are single-cycle, registered-state decoded, glitch-free.
- Acks outside FETCH/MEM are ignored; resume outside HALT ignored.

## Configuration
- CUST_OP_EN defined: cust → CUST; cust_start pulses on entry; wait for cust_done (no timeout) → WB with rf_we=1.
- Undefined: CUST state unreachable, cust_start tied 0, cust_done ignored; cust_op traps as illegal (cause 2).

## Test plan
- addi, imem_ack first cycle → states 0,1,2,4; rf_we and pc_we high cycle 4, pc_sel=00.
- lw, dmem_ack after 3 waits → dmem_req 4 cycles, dmem_we=0, rf_we in WB; total 8 cycles.
- beq, br_taken=1 → WB pc_sel=01, rf_we=0; br_taken=0 → pc_sel=00.
- invalid=1 → TRAP trap=1, trap_cause=2, pc_sel=10; ecall → cause 11.
- imem_ack never, TIMEOUT=16 → imem_req drops after 16 cycles, trap cause 1; ack on 16th cycle → normal DECODE.
- ebreak → halted=1 held 10 cycles; resume pulse → pc_we, pc_sel=00, back to FETCH; rst_n low mid-MEM → all outputs 0 immediately.
